// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic_light R/G/Y interface: runs a cycle-exact
// reference model of the light sequence and reports per-cycle disagreements.
module traffic_light_monitor #(
  parameter int unsigned T_G0 = 1024,
  parameter int unsigned T_N  = 128,
  parameter int unsigned T_GS = 128,
  parameter int unsigned T_Y  = 512,
  parameter int unsigned T_R  = 1024,
  parameter int unsigned ECW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pass,
  input  logic           R,
  input  logic           G,
  input  logic           Y,
  output logic [2:0]     exp_rgy,
  output logic [2:0]     phase,
  output logic           mismatch,
  output logic           illegal,
  output logic [ECW-1:0] err_cnt,
  output logic [ECW-1:0] first_err,
  output logic           err_seen
);

  typedef enum logic [2:0] {
    PH_G0 = 3'd0,
    PH_N1 = 3'd1,
    PH_G1 = 3'd2,
    PH_N2 = 3'd3,
    PH_G2 = 3'd4,
    PH_Y  = 3'd5,
    PH_R  = 3'd6
  } phase_e;

  localparam int unsigned T_M0  = (T_G0 > T_N)  ? T_G0 : T_N;
  localparam int unsigned T_M1  = (T_GS > T_Y)  ? T_GS : T_Y;
  localparam int unsigned T_M2  = (T_M0 > T_M1) ? T_M0 : T_M1;
  localparam int unsigned T_MAX = (T_M2 > T_R)  ? T_M2 : T_R;
  localparam int          CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  phase_e          state_q, state_d;
  phase_e          succ;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   len_m1;

  logic [2:0]      obs_rgy;
  logic            mismatch_d, illegal_d;
  logic            mismatch_q, illegal_q, err_seen_q;
  logic [ECW-1:0]  stamp_q, err_cnt_q, first_err_q;

  // ---------------------------------------------------------------------------
  // Reference model: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PH_G0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reference model: next state. A pedestrian request outside G0 wins over timeout.
  // NOTE: every combinational output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    len_m1  = CW'(T_G0 - 1);
    succ    = PH_N1;
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      PH_G0:   begin len_m1 = CW'(T_G0 - 1); succ = PH_N1; end
      PH_N1:   begin len_m1 = CW'(T_N  - 1); succ = PH_G1; end
      PH_G1:   begin len_m1 = CW'(T_GS - 1); succ = PH_N2; end
      PH_N2:   begin len_m1 = CW'(T_N  - 1); succ = PH_G2; end
      PH_G2:   begin len_m1 = CW'(T_GS - 1); succ = PH_Y;  end
      PH_Y:    begin len_m1 = CW'(T_Y  - 1); succ = PH_R;  end
      PH_R:    begin len_m1 = CW'(T_R  - 1); succ = PH_G0; end
      default: begin len_m1 = '0;            succ = PH_G0; end
    endcase
    if (pass && (state_q != PH_G0)) begin
      state_d = PH_G0;
      cnt_d   = '0;
    end else if (cnt_q == len_m1) begin
      state_d = succ;
      cnt_d   = '0;
    end
  end

  // Reference model: expected lights, purely a function of the current phase.
  always_comb begin
    exp_rgy = 3'b010;
    case (state_q)
      PH_G0, PH_G1, PH_G2: exp_rgy = 3'b010;
      PH_N1, PH_N2:        exp_rgy = 3'b000;
      PH_Y:                exp_rgy = 3'b001;
      PH_R:                exp_rgy = 3'b100;
      default:             exp_rgy = 3'b000;
    endcase
  end

  assign phase = state_q;

  // ---------------------------------------------------------------------------
  // Compare path
  // ---------------------------------------------------------------------------
  assign obs_rgy = {R, G, Y};

  // NOTE: the compare defaults to "bad" and only clears on a definite equality,
  // so an unknown on R/G/Y resolves to a mismatch instead of an X.
  always_comb begin
    mismatch_d = 1'b1;
    if (obs_rgy == exp_rgy) begin
      mismatch_d = 1'b0;
    end
    illegal_d = 1'b0;
    if ((R & G) | (R & Y) | (G & Y)) begin
      illegal_d = 1'b1;
    end
    if (illegal_d) begin
      mismatch_d = 1'b1;
    end
  end

  // first_err records the stamp of the offending cycle, i.e. before it advances.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stamp_q     <= '0;
      mismatch_q  <= 1'b0;
      illegal_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
    end else begin
      stamp_q    <= stamp_q + ECW'(1);
      mismatch_q <= mismatch_d;
      illegal_q  <= illegal_d;
      if (mismatch_d && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ECW'(1);
      end
      if (mismatch_d && !err_seen_q) begin
        first_err_q <= stamp_q;
        err_seen_q  <= 1'b1;
      end
    end
  end

  assign mismatch  = mismatch_q;
  assign illegal   = illegal_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign err_seen  = err_seen_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: a golden light generator drives the
// checker, expectations are queued per cycle and compared by a separate monitor.
module tb_traffic_light_monitor;

  logic        clk, rst, rst2, pass, r_i, g_i, y_i;
  logic        zero_pass, zero_r, zero_g, zero_y;
  logic [2:0]  exp1, ph1, exp2, ph2;
  logic        mm1, il1, seen1, mm2, il2, seen2;
  logic [15:0] cnt1, fe1;
  logic [7:0]  cnt2, fe2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          stamp;
    logic [2:0]  exp_rgy;
    logic [2:0]  phase;
    logic        mm;
    logic        il;
    logic [15:0] cnt;
    logic [15:0] fe;
    logic        seen;
    bit          v2;
    logic        mm2;
    logic [7:0]  cnt2;
    logic        seen2;
    bit          hc;
    int          hc_phase;
    int          hc_cnt;
    int          hc_fe;
  } exp_t;

  exp_t q[$];

  // Hand-computed checkpoints: {run, stamp, phase, err_cnt, first_err}
  localparam int NHC = 20;
  int hc_tab [NHC][5] = '{
    '{0,  500, 0, 0,    0}, '{0,  501, 0, 0,    0}, '{0, 1023, 0, 0,    0},
    '{0, 1024, 1, 0,    0}, '{0, 1031, 1, 1, 1030}, '{0, 1152, 2, 1, 1030},
    '{0, 1280, 3, 1, 1030}, '{0, 1408, 4, 1, 1030}, '{0, 1536, 5, 1, 1030},
    '{0, 2048, 6, 1, 1030}, '{0, 3001, 6, 2, 1030}, '{0, 3071, 6, 2, 1030},
    '{0, 3072, 0, 2, 1030},
    '{1, 1023, 0, 0,    0}, '{1, 1024, 1, 0,    0}, '{1, 2600, 6, 0,    0},
    '{1, 2601, 0, 0,    0}, '{1, 2603, 0, 0,    0}, '{1, 3624, 0, 0,    0},
    '{1, 3625, 1, 0,    0}
  };

  traffic_light_monitor u_dut (
    .clk(clk), .rst(rst), .pass(pass), .R(r_i), .G(g_i), .Y(y_i),
    .exp_rgy(exp1), .phase(ph1), .mismatch(mm1), .illegal(il1),
    .err_cnt(cnt1), .first_err(fe1), .err_seen(seen1)
  );

  traffic_light_monitor #(.ECW(8)) u_sat (
    .clk(clk), .rst(rst2), .pass(zero_pass), .R(zero_r), .G(zero_g), .Y(zero_y),
    .exp_rgy(exp2), .phase(ph2), .mismatch(mm2), .illegal(il2),
    .err_cnt(cnt2), .first_err(fe2), .err_seen(seen2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int stamp,
                       input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s stamp=%0d got=%0h want=%0h", name, stamp, act, want);
    end
  endtask

  // Golden light pattern by position in the 3072-cycle loop.
  function automatic logic [2:0] gold_rgy(input int t);
    if (t < 1024)      return 3'b010;
    else if (t < 1152) return 3'b000;
    else if (t < 1280) return 3'b010;
    else if (t < 1408) return 3'b000;
    else if (t < 1536) return 3'b010;
    else if (t < 2048) return 3'b001;
    else               return 3'b100;
  endfunction

  function automatic logic [2:0] gold_phase(input int t);
    if (t < 1024)      return 3'd0;
    else if (t < 1152) return 3'd1;
    else if (t < 1280) return 3'd2;
    else if (t < 1408) return 3'd3;
    else if (t < 1536) return 3'd4;
    else if (t < 2048) return 3'd5;
    else               return 3'd6;
  endfunction

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("exp_rgy",   e.stamp, exp1,  e.exp_rgy);
      check("phase",     e.stamp, ph1,   e.phase);
      check("mismatch",  e.stamp, mm1,   e.mm);
      check("illegal",   e.stamp, il1,   e.il);
      check("err_cnt",   e.stamp, cnt1,  e.cnt);
      check("first_err", e.stamp, fe1,   e.fe);
      check("err_seen",  e.stamp, seen1, e.seen);
      if (e.v2) begin
        check("sat_mismatch", e.stamp, mm2,   e.mm2);
        check("sat_err_cnt",  e.stamp, cnt2,  e.cnt2);
        check("sat_err_seen", e.stamp, seen2, e.seen2);
        check("sat_first",    e.stamp, fe2,   8'd0);
      end
      if (e.hc) begin
        check("hand_phase",     e.stamp, ph1,  e.hc_phase);
        check("hand_err_cnt",   e.stamp, cnt1, e.hc_cnt);
        check("hand_first_err", e.stamp, fe1,  e.hc_fe);
      end
    end
  end

  task automatic run(input int run_id, input int n);
    int         t = 0;
    int         cnt = 0;
    int         fe = 0;
    logic       seen = 1'b0;
    logic       mm_p = 1'b0;
    logic       il_p = 1'b0;
    logic [2:0] gold, obs;
    exp_t       e;
    for (int k = 0; k < n; k++) begin
      pass = ((run_id == 0) && (k == 500)) ||
             ((run_id == 1) && (k >= 2600) && (k <= 2602));
      gold = gold_rgy(t);
      obs  = gold;
      if ((run_id == 0) && (k == 1030)) obs = 3'b001;
      if ((run_id == 0) && (k == 3000)) obs = 3'b110;
      {r_i, g_i, y_i} = obs;

      e.stamp   = k;
      e.exp_rgy = gold;
      e.phase   = gold_phase(t);
      e.mm      = mm_p;
      e.il      = il_p;
      e.cnt     = 16'(cnt);
      e.fe      = 16'(fe);
      e.seen    = seen;
      e.v2      = (run_id == 0) && (k < 400);
      e.mm2     = (k >= 1);
      e.cnt2    = (k > 255) ? 8'd255 : 8'(k);
      e.seen2   = (k >= 1);
      e.hc      = 1'b0;
      e.hc_phase = 0;
      e.hc_cnt   = 0;
      e.hc_fe    = 0;
      for (int h = 0; h < NHC; h++) begin
        if ((hc_tab[h][0] == run_id) && (hc_tab[h][1] == k)) begin
          e.hc       = 1'b1;
          e.hc_phase = hc_tab[h][2];
          e.hc_cnt   = hc_tab[h][3];
          e.hc_fe    = hc_tab[h][4];
        end
      end
      q.push_back(e);

      if ((run_id == 0) && (k == 400)) begin
        #1 rst2 = 1'b0;
        #1;
        check("sat_rst_mismatch",  k, mm2,   1'b0);
        check("sat_rst_illegal",   k, il2,   1'b0);
        check("sat_rst_err_cnt",   k, cnt2,  8'd0);
        check("sat_rst_first_err", k, fe2,   8'd0);
        check("sat_rst_err_seen",  k, seen2, 1'b0);
        check("sat_rst_phase",     k, ph2,   3'd0);
        check("sat_rst_exp_rgy",   k, exp2,  3'b010);
      end

      mm_p = (obs !== gold);
      il_p = ($countones(obs) > 1);
      if (mm_p) begin
        if (cnt < 65535) cnt++;
        if (!seen) begin
          seen = 1'b1;
          fe   = k;
        end
      end
      t = (pass && (t >= 1024)) ? 0 : (t + 1) % 3072;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_exp_rgy"},   -1, exp1,  3'b010);
    check({tag, "_phase"},     -1, ph1,   3'd0);
    check({tag, "_mismatch"},  -1, mm1,   1'b0);
    check({tag, "_illegal"},   -1, il1,   1'b0);
    check({tag, "_err_cnt"},   -1, cnt1,  16'd0);
    check({tag, "_first_err"}, -1, fe1,   16'd0);
    check({tag, "_err_seen"},  -1, seen1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0; pass = 1'b0;
    r_i = 1'b0; g_i = 1'b1; y_i = 1'b0;
    zero_pass = 1'b0; zero_r = 1'b0; zero_g = 1'b0; zero_y = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    rst = 1'b1; rst2 = 1'b1;

    run(0, 3100);

    // Mid-phase reset with a non-zero error count behind it.
    rst = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    run(1, 3700);

    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", -1, q.size(), 0);
    check("sat_held_err_cnt", -1, cnt2, 8'd0);
    check("sat_held_phase",   -1, ph2,  3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
